nibble_display: RTL

NIBBLE_DISPLAY -- requirements
Module: nibble_display

---
 rtl/nibble_display_pkg.sv | 21 ++
 rtl/nibble_display_hex.sv | 11 +
 rtl/nibble_display.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nibble_display_pkg.sv
// Shared types and constants for nibble_display and other seven-segment display blocks.
// Segments are active-low, bit 6 = A through bit 0 = G.
package nibble_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs 0-F; b and d are lowercase so they stay distinct from 8 and 0.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/nibble_display_hex.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_segments
    import nibble_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    assign o_segments = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/nibble_display.sv
// Single-digit hex display that blinks the digit whenever its value changes.
// The blink sequencer exists only when NIBBLE_DISPLAY_BLINK_EN is defined.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | steady display of the held value, not busy
//   ST_BLANK | all segments off for one phase
//   ST_SHOW  | held value shown for one phase, then next pair or idle
module nibble_display
    import nibble_display_pkg::*;
#(
    parameter int CLKS_PER_PHASE = 2500000,
    parameter int BLINK_COUNT    = 3
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic [3:0] i_Nibble,
    input  logic       i_Load,
    output logic [6:0] o_Segments,
    output logic       o_Busy
);

    if (CLKS_PER_PHASE < 2 || BLINK_COUNT < 1) begin : g_bad_params
        $error("nibble_display: CLKS_PER_PHASE must be >= 2 and BLINK_COUNT >= 1");
    end

    logic [3:0] r_value_q;
    logic [3:0] r_value_d;
    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic [6:0] glyph_next;
    logic       change;

    // A load of the value already held is not a change and must leave everything untouched.
    assign change = i_Load && (i_Nibble != r_value_q);

    always_comb begin
        r_value_d = r_value_q;
        if (change) begin
            r_value_d = i_Nibble;
        end
    end

    // Decode the next value so the segment register lines up with r_value_q.
    hex_to_segments u_hex (
        .i_nibble   (r_value_d),
        .o_segments (glyph_next)
    );

    assign o_Segments = seg_q;

`ifdef NIBBLE_DISPLAY_BLINK_EN

    localparam int PH_W = $clog2(CLKS_PER_PHASE);
    localparam int PR_W = $clog2(BLINK_COUNT + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_PHASE - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(BLINK_COUNT - 1);

    state_e          state_q;
    state_e          state_d;
    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;
    logic [PR_W-1:0] pair_q;
    logic [PR_W-1:0] pair_d;
    logic            busy_q;
    logic            busy_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pair_d  = pair_q;
        if (change) begin
            state_d = ST_BLANK;
            phase_d = '0;
            pair_d  = '0;
        end else begin
            unique case (state_q)
                ST_BLANK: begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        state_d = ST_SHOW;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (pair_q == PR_LAST) begin
                            pair_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            pair_d  = pair_q + PR_W'(1);
                            state_d = ST_BLANK;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                default: ;
            endcase
        end
        seg_d  = (state_d == ST_BLANK) ? SEG_BLANK : glyph_next;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            pair_q    <= '0;
            r_value_q <= 4'h0;
            seg_q     <= SEG_GLYPH[0];
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pair_q    <= pair_d;
            r_value_q <= r_value_d;
            seg_q     <= seg_d;
            busy_q    <= busy_d;
        end
    end

    assign o_Busy = busy_q;

`else

    assign seg_d = glyph_next;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_value_q <= 4'h0;
            seg_q     <= SEG_GLYPH[0];
        end else begin
            r_value_q <= r_value_d;
            seg_q     <= seg_d;
        end
    end

    assign o_Busy = 1'b0;

`endif

endmodule
